// File: rtl/msk_demux_fifo.sv
// Masked 1-to-2 demultiplexer with a 2-entry FIFO.
// Each incoming sharing is steered to the true or false port by a
// non-sensitive select bit. Shares are only stored and steered, never combined.
module msk_demux_fifo #(
    parameter int d     = 2,
    parameter int count = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sel,
    input  logic [count*d-1:0]   in_data,
    output logic                 out_true_valid,
    input  logic                 out_true_ready,
    output logic [count*d-1:0]   out_true_data,
    output logic                 out_false_valid,
    input  logic                 out_false_ready,
    output logic [count*d-1:0]   out_false_data
);

    localparam int W = count * d;

    logic [W-1:0] mem_data [2];
    logic         mem_dest [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic [1:0]   cnt_next;
    logic         push;
    logic         pop;
    logic         head_valid;
    logic         head_dest;
    logic [W-1:0] head_data;

    assign head_valid = (cnt != 2'd0);
    assign head_dest  = mem_dest[rd_ptr];
    assign head_data  = mem_data[rd_ptr];

    assign out_true_valid  = head_valid & head_dest;
    assign out_false_valid = head_valid & ~head_dest;

    // Gating uses only the non-sensitive valid bit, so each share lane stays separate.
    assign out_true_data  = head_data & {W{out_true_valid}};
    assign out_false_data = head_data & {W{out_false_valid}};

    assign push = in_valid & in_ready;
    assign pop  = (out_true_valid & out_true_ready) | (out_false_valid & out_false_ready);

    // Occupancy after this cycle's push/pop, also used to register in_ready.
    always_comb begin
        cnt_next = cnt;
        if (push && !pop) begin
            cnt_next = cnt + 2'd1;
        end else if (!push && pop) begin
            cnt_next = cnt - 2'd1;
        end
    end

    // Pointer, occupancy and ready registers; reset drops all buffered entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            cnt      <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt      <= cnt_next;
            in_ready <= (cnt_next != 2'd2);
        end
    end

    // Entry storage; cleared on reset so no stale sharing survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_dest[0] <= 1'b0;
            mem_dest[1] <= 1'b0;
        end else if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_dest[wr_ptr] <= sel;
        end
    end

endmodule

// File: tb/tb_msk_demux_fifo.sv
// Self-checking bench for msk_demux_fifo (d=2, count=4 -> 8-bit bus).
// A queue model of the FIFO is updated on every clock edge from the driven
// stimulus and compared against the DUT outputs on the falling edge.
module tb_msk_demux_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       sel;
    logic [7:0] in_data;
    logic       out_true_valid;
    logic       out_true_ready;
    logic [7:0] out_true_data;
    logic       out_false_valid;
    logic       out_false_ready;
    logic [7:0] out_false_data;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    logic [8:0] sb_q [$];
    bit         model_ready = 1'b1;
    bit         last_push   = 1'b0;
    bit         do_push;
    bit         do_pop;
    int         delivered   = 0;

    msk_demux_fifo #(.d(2), .count(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .sel             (sel),
        .in_data         (in_data),
        .out_true_valid  (out_true_valid),
        .out_true_ready  (out_true_ready),
        .out_true_data   (out_true_data),
        .out_false_valid (out_false_valid),
        .out_false_ready (out_false_ready),
        .out_false_data  (out_false_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: a 2-deep queue updated with the same push/pop rules.
    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
            model_ready = 1'b1;
            last_push   = 1'b0;
        end else begin
            do_push = in_valid && model_ready;
            do_pop  = (sb_q.size() != 0) && (sb_q[0][8] ? out_true_ready : out_false_ready);
            if (do_pop) begin
                void'(sb_q.pop_front());
                delivered++;
            end
            if (do_push) begin
                sb_q.push_back({sel, in_data});
            end
            model_ready = (sb_q.size() != 2);
            last_push   = do_push;
        end
    end

    // Compare DUT outputs to the model away from the active edge.
    always @(negedge clk) begin
        logic       exp_tv;
        logic       exp_fv;
        logic [7:0] exp_td;
        logic [7:0] exp_fd;
        if (checking) begin
            exp_tv = (sb_q.size() != 0) && sb_q[0][8];
            exp_fv = (sb_q.size() != 0) && !sb_q[0][8];
            exp_td = exp_tv ? sb_q[0][7:0] : 8'h00;
            exp_fd = exp_fv ? sb_q[0][7:0] : 8'h00;
            checkOutput("in_ready",        32'(in_ready),        32'(model_ready));
            checkOutput("out_true_valid",  32'(out_true_valid),  32'(exp_tv));
            checkOutput("out_false_valid", 32'(out_false_valid), 32'(exp_fv));
            checkOutput("out_true_data",   32'(out_true_data),   32'(exp_td));
            checkOutput("out_false_data",  32'(out_false_data),  32'(exp_fd));
        end
    end

    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] dat);
        in_valid = v;
        sel      = s;
        in_data  = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic holdUntilAccepted(input logic s, input logic [7:0] dat);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, s, dat);
            if (last_push) break;
        end
        checkOutput("accept_timeout", 32'(last_push), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        int base;
        // Reset with in_valid high: nothing may be captured.
        rst             = 1'b1;
        in_valid        = 1'b1;
        sel             = 1'b1;
        in_data         = 8'hEE;
        out_true_ready  = 1'b1;
        out_false_ready = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        checking = 1'b1;
        idle(2);

        $display("[TB] routing");
        applyStimulus(1'b1, 1'b1, 8'hA5);
        applyStimulus(1'b1, 1'b0, 8'h3C);
        idle(3);

        $display("[TB] full and backpressure");
        out_true_ready  = 1'b0;
        out_false_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h11);
        applyStimulus(1'b1, 1'b1, 8'h22);
        applyStimulus(1'b1, 1'b1, 8'h33);
        applyStimulus(1'b1, 1'b1, 8'h33);
        out_true_ready = 1'b1;
        holdUntilAccepted(1'b1, 8'h33);
        idle(4);
        out_false_ready = 1'b1;

        $display("[TB] head-of-line blocking");
        out_false_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b1, 8'h66);
        idle(3);
        out_false_ready = 1'b1;
        idle(3);

        $display("[TB] pointer wrap at full throughput");
        base = delivered;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'(i % 2), 8'(i * 17 + 3));
        end
        idle(2);
        checkOutput("wrap_delivered", 32'(delivered - base), 32'd10);

        $display("[TB] reset mid-operation");
        out_true_ready  = 1'b0;
        out_false_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h77);
        applyStimulus(1'b1, 1'b0, 8'h88);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'hCC);
        rst = 1'b0;
        idle(1);
        out_true_ready  = 1'b1;
        out_false_ready = 1'b1;
        base = delivered;
        applyStimulus(1'b1, 1'b0, 8'h99);
        idle(2);
        checkOutput("post_reset_delivered", 32'(delivered - base), 32'd1);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
